mem_wb_writeback: RTL and testbench

- Consumer end of the MEM/WB pipeline latch: accepts the latched write-back request (write, quarter, stall) plus destination/data, performs sub-word lane merge, and commits into the integer register file.
- Provides two combinational read ports to decode, with same-cycle write bypass, so ID sees the WB result without an extra stall.
- Keeps a sticky misalignment flag and a retired-write counter for debug/perf.

---
 rtl/mem_wb_writeback.sv | 133 +++++++++++++
 tb/tb_mem_wb_writeback.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_wb_writeback.sv
// Write-back stage: merges sub-word lanes into the integer register file and
// serves two combinational decode read ports with same-cycle write bypass.
module mem_wb_writeback #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 16,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write,
    input  logic [1:0]        quarter,
    input  logic [1:0]        size,
    input  logic              stall,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic [ADDR_W:0] NUM_REGS_EXT = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0] regs_reg [NUM_REGS];
    logic              misalign_reg;
    logic [CNT_W-1:0]  wr_count_reg;

    logic              align_ok;
    logic              addr_ok;
    logic              req;
    logic              commit;
    logic              illegal;
    logic [3:0]        lane_en;
    logic [DATA_W-1:0] lane_data;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] merged;
    logic [NUM_REGS-1:0] we;
    logic              wr_to_zero;
    logic [DATA_W-1:0] stored_a;
    logic [DATA_W-1:0] stored_b;

    always_comb begin
        align_ok  = 1'b0;
        lane_en   = 4'b1111;
        lane_data = wr_data;
        case (size)
            2'b00: begin
                align_ok  = 1'b1;
                lane_en   = 4'b0001 << quarter;
                lane_data = {4{wr_data[7:0]}};
            end
            2'b01: begin
                align_ok  = ~quarter[0];
                lane_en   = quarter[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wr_data[15:0]}};
            end
            2'b10: begin
                align_ok  = (quarter == 2'b00);
            end
            default: begin
                align_ok  = 1'b0;
            end
        endcase
    end

    assign addr_ok    = ({1'b0, wr_addr} < NUM_REGS_EXT);
    assign req        = write & ~stall;
    assign commit     = req & align_ok & addr_ok;
    assign illegal    = req & ~(align_ok & addr_ok);
    assign wr_to_zero = ZERO_REG && (wr_addr == '0);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
            assign lane_mask[8*gi +: 8] = {8{lane_en[gi]}};
        end
    endgenerate

    always_comb begin
        wr_old = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_addr == ADDR_W'(i)) wr_old = regs_reg[i];
        end
    end

    // Bypass and commit both use this merge, so ID never sees raw wr_data.
    assign merged = (wr_old & ~lane_mask) | (lane_data & lane_mask);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_we
            if (ZERO_REG && gi == 0) begin : g_zero
                assign we[gi] = 1'b0;
            end else begin : g_norm
                assign we[gi] = commit && (wr_addr == ADDR_W'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
            misalign_reg <= 1'b0;
            wr_count_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we[i]) regs_reg[i] <= merged;
            end
            if (illegal) misalign_reg <= 1'b1;
            if (commit)  wr_count_reg <= wr_count_reg + CNT_W'(1);
        end
    end

    // Out-of-range indices match no entry and fall through to zero.
    always_comb begin
        stored_a = '0;
        stored_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_a == ADDR_W'(i)) stored_a = regs_reg[i];
            if (rd_addr_b == ADDR_W'(i)) stored_b = regs_reg[i];
        end
    end

    assign rd_data_a = (commit && !wr_to_zero && rd_addr_a == wr_addr) ? merged : stored_a;
    assign rd_data_b = (commit && !wr_to_zero && rd_addr_b == wr_addr) ? merged : stored_b;

    assign misalign_err = misalign_reg;
    assign wr_count     = wr_count_reg;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed-vector bench for mem_wb_writeback: lane merge, bypass, stall,
// misalignment, zero register, range checks, async reset and counter wrap.
module tb_mem_wb_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        write;
    logic [1:0]  quarter;
    logic [1:0]  size;
    logic        stall;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        misalign_err;
    logic [3:0]  wr_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_R = 2'b11;

    mem_wb_writeback #(
        .NUM_REGS(24), .ADDR_W(5), .DATA_W(32), .CNT_W(4), .ZERO_REG(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .write(write), .quarter(quarter), .size(size),
        .stall(stall), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .misalign_err(misalign_err), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s: got %h", tag, got);
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one request across a rising edge, then idle the bus.
    task automatic wb(input logic [4:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic [1:0] q);
        write = 1'b1; wr_addr = a; wr_data = d; size = sz; quarter = q; stall = 1'b0;
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        rd_addr_a = a; rd_addr_b = a;
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        check(tag, {28'b0, wr_count}, 32'(exp_cnt % 16));
    endtask

    initial begin
        rst_n = 1'b0; write = 1'b0; quarter = 2'b00; size = SZ_W; stall = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        rd(5'd5);
        check("reset_r5", rd_data_a, 32'h0);
        check("reset_cnt", {28'b0, wr_count}, 32'h0);
        check("reset_err", {31'b0, misalign_err}, 32'h0);

        wb(5'd5, 32'h11223344, SZ_W, 2'd0); exp_cnt++;
        rd(5'd5);
        check("word_r5", rd_data_a, 32'h11223344);
        wb(5'd5, 32'h000000AA, SZ_B, 2'd2); exp_cnt++;
        rd(5'd5);
        check("byte_q2_r5", rd_data_a, 32'h11AA3344);
        chk_cnt("cnt_after_merge");

        wb(5'd7, 32'hDEADBEEF, SZ_W, 2'd0); exp_cnt++;
        rd(5'd7);
        write = 1'b1; wr_addr = 5'd7; wr_data = 32'h00001234; size = SZ_H; quarter = 2'd2;
        #1;
        check("bypass_a_half", rd_data_a, 32'h1234BEEF);
        check("bypass_b_half", rd_data_b, 32'h1234BEEF);
        @(posedge clk); #1; write = 1'b0; exp_cnt++;
        rd(5'd7);
        check("stored_half", rd_data_a, 32'h1234BEEF);

        rd(5'd4);
        write = 1'b1; stall = 1'b1; wr_addr = 5'd4; wr_data = 32'hCAFEF00D; size = SZ_W; quarter = 2'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_no_bypass", rd_data_a, 32'h0);
            @(posedge clk); #1;
        end
        check("stall_r4", rd_data_a, 32'h0);
        chk_cnt("stall_cnt");
        stall = 1'b0;
        #1;
        check("unstall_bypass", rd_data_a, 32'hCAFEF00D);
        @(posedge clk); #1; write = 1'b0; exp_cnt++;
        check("unstall_r4", rd_data_a, 32'hCAFEF00D);
        chk_cnt("unstall_cnt");

        rd(5'd0);
        write = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; size = SZ_W; quarter = 2'd0;
        #1;
        check("r0_no_bypass", rd_data_a, 32'h0);
        @(posedge clk); #1; write = 1'b0; exp_cnt++;
        check("r0_reads_zero", rd_data_a, 32'h0);
        chk_cnt("r0_counted");

        wb(5'd9, 32'h00000000, SZ_W, 2'd0); exp_cnt++;
        wb(5'd9, 32'h0000005A, SZ_B, 2'd3); exp_cnt++;
        rd(5'd9);
        check("byte_q3_r9", rd_data_a, 32'h5A000000);
        wb(5'd9, 32'hFFFFBEEF, SZ_H, 2'd0); exp_cnt++;
        rd(5'd9);
        check("half_q0_r9", rd_data_a, 32'h5A00BEEF);
        check("err_still_clear", {31'b0, misalign_err}, 32'h0);

        wb(5'd30, 32'h12345678, SZ_W, 2'd0);
        rd(5'd30);
        check("oor_read_zero", rd_data_a, 32'h0);
        check("oor_sets_err", {31'b0, misalign_err}, 32'h1);
        chk_cnt("oor_not_counted");

        // Asynchronous reset asserted mid-cycle, checked before any edge.
        rd(5'd5);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_r5", rd_data_a, 32'h0);
        check("async_rst_cnt", {28'b0, wr_count}, 32'h0);
        check("async_rst_err", {31'b0, misalign_err}, 32'h0);
        rd(5'd9);
        check("async_rst_r9", rd_data_b, 32'h0);
        #1 rst_n = 1'b1;
        exp_cnt = 0;
        @(posedge clk); #1;

        wb(5'd3, 32'h0000FFFF, SZ_H, 2'd1);
        rd(5'd3);
        check("mis_half_r3", rd_data_a, 32'h0);
        check("mis_half_err", {31'b0, misalign_err}, 32'h1);
        chk_cnt("mis_half_cnt");
        wb(5'd8, 32'h77777777, SZ_R, 2'd0);
        rd(5'd8);
        check("reserved_r8", rd_data_a, 32'h0);
        wb(5'd8, 32'h77777777, SZ_W, 2'd2);
        check("mis_word_r8", rd_data_a, 32'h0);
        wb(5'd3, 32'h00000055, SZ_W, 2'd0); exp_cnt++;
        rd(5'd3);
        check("legal_after_err", rd_data_a, 32'h00000055);
        check("err_sticky", {31'b0, misalign_err}, 32'h1);
        chk_cnt("cnt_after_err");

        for (int i = 0; i < 14; i++) begin
            wb(5'd10, 32'(i), SZ_W, 2'd0); exp_cnt++;
        end
        check("cnt_at_15", {28'b0, wr_count}, 32'd15);
        wb(5'd10, 32'hA5A5A5A5, SZ_W, 2'd0); exp_cnt++;
        check("cnt_wrap_0", {28'b0, wr_count}, 32'd0);
        rd(5'd10);
        check("last_wrap_data", rd_data_a, 32'hA5A5A5A5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
